ternary_neuron_scheduler: RTL and testbench

Time-multiplexed neuron controller for the ternary synapse datapath. It holds one neuron's ternary weights and accepts a binary input vector over a valid/ready handshake. It sequences the vector through `LANES` ternary synapse multipliers over several beats, accumulates the signed products and returns the sum plus a thresholded fire bit over a second valid/ready handshake. It sits between the input-vector source and downstream activation/readout logic, and is the block that shares the multiplier lanes across all `N_SYN` synapses.

---
 rtl/ternary_neuron_scheduler.sv | 154 +++++++++++++++
 tb/tb_ternary_neuron_scheduler.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ternary_neuron_scheduler.sv
// ternary_neuron_scheduler: one neuron's ternary weights, a binary input vector
// accepted over valid/ready, evaluated LANES synapses per beat, and a signed
// sum plus a thresholded fire bit returned over valid/ready.
module ternary_neuron_scheduler #(
  parameter int N_SYN = 16,
  parameter int LANES = 4,
  parameter int ACC_W = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     w_wr_en,
  input  logic [$clog2(N_SYN)-1:0] w_addr,
  input  logic [1:0]               w_data,
  output logic                     w_ready,
  input  logic                     x_valid,
  output logic                     x_ready,
  input  logic [N_SYN-1:0]         x_data,
  input  logic [ACC_W-1:0]         threshold,
  output logic                     y_valid,
  input  logic                     y_ready,
  output logic [ACC_W-1:0]         y_sum,
  output logic                     y_fire,
  output logic                     busy
);

  localparam int ADDR_W = $clog2(N_SYN);
  localparam int BEATS  = N_SYN / LANES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0]        LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic signed [ACC_W-1:0] ONE       = ACC_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_n;

  // Weights held as two flag planes: zero flag and sign flag per synapse.
  logic [N_SYN-1:0]         w_zero;
  logic [N_SYN-1:0]         w_sign;
  logic [N_SYN-1:0]         x_cap;
  logic signed [ACC_W-1:0]  thr_cap;
  logic signed [ACC_W-1:0]  acc;
  logic [BEAT_W-1:0]        beat;

  logic                     accept;
  logic                     step;
  logic                     last_beat;
  logic [ADDR_W-1:0]        base;
  logic [ADDR_W-1:0]        idx;
  logic signed [ACC_W-1:0]  beat_sum;
  logic signed [ACC_W-1:0]  acc_next;
  logic                     fire_next;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // skipped an assignment would infer a latch.
    state_n   = state;
    x_ready   = 1'b0;
    w_ready   = 1'b0;
    y_valid   = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    step      = 1'b0;
    last_beat = 1'b0;
    case (state)
      IDLE: begin
        x_ready = ~rst;
        w_ready = ~rst;
        if (x_valid && !rst) begin
          accept  = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (beat == LAST_BEAT) begin
          last_beat = 1'b1;
          state_n   = DONE;
        end
      end
      DONE: begin
        busy    = 1'b1;
        y_valid = ~rst;
        if (y_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Sum of the ternary products for the synapses of the current beat.
  always_comb begin
    beat_sum = '0;
    idx      = '0;
    base     = ADDR_W'(int'(beat) * LANES);
    for (int l = 0; l < LANES; l++) begin
      idx = base + ADDR_W'(l);
      if (x_cap[idx] && !w_zero[idx]) begin
        if (w_sign[idx]) beat_sum = beat_sum - ONE;
        else             beat_sum = beat_sum + ONE;
      end
    end
    acc_next  = acc + beat_sum;
    fire_next = acc_next > thr_cap;
  end

  // Weight storage, vector capture, accumulation and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the weight file is reset on purpose: a cleared neuron must read
      // as all-zero weights, so this storage cannot be left uninitialised.
      w_zero  <= '1;
      w_sign  <= '0;
      x_cap   <= '0;
      thr_cap <= '0;
      acc     <= '0;
      beat    <= '0;
      y_sum   <= '0;
      y_fire  <= 1'b0;
    end else begin
      // A write in the accept cycle lands before the first beat reads it.
      if (w_ready && w_wr_en) begin
        w_zero[w_addr] <= w_data[0];
        w_sign[w_addr] <= w_data[1];
      end
      if (accept) begin
        x_cap   <= x_data;
        thr_cap <= threshold;
        acc     <= '0;
        beat    <= '0;
      end else if (step) begin
        acc  <= acc_next;
        beat <= last_beat ? '0 : beat + BEAT_W'(1);
        if (last_beat) begin
          y_sum  <= acc_next;
          y_fire <= fire_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_ternary_neuron_scheduler.sv
// Self-checking bench for ternary_neuron_scheduler: directed table vectors,
// hand-written multi-cycle sequences, and random vectors against a model.
module tb_ternary_neuron_scheduler;

  localparam int N_SYN = 16;
  localparam int LANES = 4;
  localparam int ACC_W = 6;
  localparam int LAT   = N_SYN / LANES + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             w_wr_en;
  logic [3:0]       w_addr;
  logic [1:0]       w_data;
  logic             w_ready;
  logic             x_valid;
  logic             x_ready;
  logic [N_SYN-1:0] x_data;
  logic [ACC_W-1:0] threshold;
  logic             y_valid;
  logic             y_ready;
  logic [ACC_W-1:0] y_sum;
  logic             y_fire;
  logic             busy;

  ternary_neuron_scheduler #(.N_SYN(N_SYN), .LANES(LANES), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst),
    .w_wr_en(w_wr_en), .w_addr(w_addr), .w_data(w_data), .w_ready(w_ready),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data), .threshold(threshold),
    .y_valid(y_valid), .y_ready(y_ready), .y_sum(y_sum), .y_fire(y_fire),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference weights as plain integers -1/0/+1.
  int w_m [N_SYN];

  typedef struct {
    int          wpat;
    logic [15:0] x;
    int          thr;
    int          exp_sum;
    bit          exp_fire;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int model_sum(input logic [N_SYN-1:0] x);
    int s = 0;
    for (int i = 0; i < N_SYN; i++) if (x[i]) s += w_m[i];
    return s;
  endfunction

  function automatic int decode_w(input logic [1:0] d);
    if (d[0]) return 0;
    return d[1] ? -1 : 1;
  endfunction

  // Starts and ends just after a rising edge with the DUT in IDLE.
  task automatic write_w(input int addr, input logic [1:0] d);
    w_wr_en = 1'b1;
    w_addr  = 4'(addr);
    w_data  = d;
    @(posedge clk); #1;
    w_wr_en = 1'b0;
    w_m[addr] = decode_w(d);
  endtask

  task automatic load_pattern(input int p);
    for (int i = 0; i < N_SYN; i++) begin
      if (p == 0)      write_w(i, 2'b00);
      else if (p == 2) write_w(i, 2'b10);
      else             write_w(i, (i % 2 == 0) ? 2'b00 : 2'b10);
    end
  endtask

  // Called right after the accept edge; returns the cycle y_valid is seen.
  task automatic wait_y(output int lat);
    @(negedge clk);
    lat = 1;
    while (!y_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_vector(input logic [N_SYN-1:0] x, input int thr,
                            output int s, output int f, output int lat);
    x_valid   = 1'b1;
    x_data    = x;
    threshold = ACC_W'(thr);
    @(negedge clk);
    check("x_ready_before_accept", int'(x_ready), 1);
    @(posedge clk); #1;
    x_valid = 1'b0;
    w_wr_en = 1'b0;
    wait_y(lat);
    s = int'($signed(y_sum));
    f = int'(y_fire);
    y_ready = 1'b1;
    @(posedge clk); #1;
    y_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, f, lat, cur_pat, bad;
    logic [N_SYN-1:0] rx;
    int rthr;

    vecs[0] = '{0, 16'h00FF,   7,   8, 1'b1};
    vecs[1] = '{0, 16'h00FF,   8,   8, 1'b0};
    vecs[2] = '{1, 16'hFFFF,   0,   0, 1'b0};
    vecs[3] = '{1, 16'h5555,   0,   8, 1'b1};
    vecs[4] = '{1, 16'hAAAA,   0,  -8, 1'b0};
    vecs[5] = '{2, 16'hFFFF, -16, -16, 1'b0};
    vecs[6] = '{2, 16'h0000,  -1,   0, 1'b1};

    rst = 1'b1; w_wr_en = 1'b0; w_addr = '0; w_data = '0;
    x_valid = 1'b0; x_data = '0; threshold = '0; y_ready = 1'b0;
    for (int i = 0; i < N_SYN; i++) w_m[i] = 0;

    // Reset behaviour.
    repeat (2) @(negedge clk);
    check("x_ready_in_reset", int'(x_ready), 0);
    check("w_ready_in_reset", int'(w_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_x_ready", int'(x_ready), 1);
    check("reset_w_ready", int'(w_ready), 1);
    check("reset_y_valid", int'(y_valid), 0);
    check("reset_busy",    int'(busy), 0);
    check("reset_y_sum",   int'($signed(y_sum)), 0);
    check("reset_y_fire",  int'(y_fire), 0);
    @(posedge clk); #1;

    // Cleared weights give zero, result latency B+1.
    run_vector(16'hFFFF, 0, s, f, lat);
    check("t1_latency", lat, LAT);
    check("t1_sum", s, 0);
    check("t1_fire", f, 0);

    // Directed table.
    cur_pat = -1;
    for (int v = 0; v < 7; v++) begin
      if (vecs[v].wpat != cur_pat) begin
        load_pattern(vecs[v].wpat);
        cur_pat = vecs[v].wpat;
      end
      run_vector(vecs[v].x, vecs[v].thr, s, f, lat);
      check($sformatf("vec%0d_latency", v), lat, LAT);
      check($sformatf("vec%0d_sum", v), s, vecs[v].exp_sum);
      check($sformatf("vec%0d_fire", v), f, int'(vecs[v].exp_fire));
    end

    // Write and accept in the same cycle: new weight applies to this vector.
    load_pattern(0);
    w_wr_en = 1'b1; w_addr = 4'd3; w_data = 2'b10;
    run_vector(16'h0008, 0, s, f, lat);
    w_m[3] = -1;
    check("wr_accept_sum", s, -1);
    check("wr_accept_fire", f, 0);
    write_w(3, 2'b00);

    // Backpressure in DONE with ignored accepts and writes.
    x_valid = 1'b1; x_data = 16'h00FF; threshold = '0;
    @(posedge clk); #1;
    x_valid = 1'b0;
    wait_y(lat);
    check("bp_latency", lat, LAT);
    check("bp_sum_first", int'($signed(y_sum)), 8);
    x_valid = 1'b1; x_data = 16'hFFFF;
    w_wr_en = 1'b1; w_addr = 4'd0; w_data = 2'b10;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_y_valid", int'(y_valid), 1);
      check("bp_y_sum", int'($signed(y_sum)), 8);
      check("bp_y_fire", int'(y_fire), 1);
      check("bp_x_ready", int'(x_ready), 0);
    end
    x_valid = 1'b0; w_wr_en = 1'b0; y_ready = 1'b1;
    @(posedge clk); #1;
    y_ready = 1'b0;
    @(negedge clk);
    check("bp_y_valid_drop", int'(y_valid), 0);
    check("bp_x_ready_back", int'(x_ready), 1);
    @(posedge clk); #1;
    run_vector(16'h0001, 0, s, f, lat);
    check("bp_weight_kept", s, model_sum(16'h0001));

    // Reset during RUN beat 2 aborts the vector and clears weights.
    x_valid = 1'b1; x_data = 16'hFFFF; threshold = '0;
    @(posedge clk); #1;
    x_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_run_busy_before", int'(busy), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < N_SYN; i++) w_m[i] = 0;
    @(negedge clk);
    check("rst_run_busy", int'(busy), 0);
    check("rst_run_y_valid", int'(y_valid), 0);
    check("rst_run_x_ready", int'(x_ready), 1);
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (y_valid || busy) bad++;
    end
    check("rst_run_no_result", bad, 0);
    @(posedge clk); #1;
    run_vector(16'hFFFF, 0, s, f, lat);
    check("rst_run_cleared_sum", s, 0);
    check("rst_run_cleared_lat", lat, LAT);

    // Random weights and vectors against the model.
    for (int i = 0; i < N_SYN; i++) write_w(i, 2'($urandom_range(0, 3)));
    for (int r = 0; r < 20; r++) begin
      rx   = N_SYN'($urandom);
      rthr = int'($urandom_range(0, 40)) - 20;
      if (r % 5 == 4) write_w(int'($urandom_range(0, N_SYN - 1)), 2'($urandom_range(0, 3)));
      run_vector(rx, rthr, s, f, lat);
      check("rand_latency", lat, LAT);
      check("rand_sum", s, model_sum(rx));
      check("rand_fire", f, (model_sum(rx) > rthr) ? 1 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
